// File: rtl/ips2l_pcie_skid_buf.sv
// Two-entry valid/ready skid buffer with fully registered s_ready/m_valid.
// Also counts completed packets (last-beat handshakes) for debug readback.
module ips2l_pcie_skid_buf #(
  parameter int DATA_WIDTH = 128,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_last_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o,
  input  logic                  cnt_clr_i,
  output logic [CNT_WIDTH-1:0]  pkt_cnt_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  s_ready_q;
  logic                  m_valid_q;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  m_last_q, m_last_d;
  logic [DATA_WIDTH-1:0] sk_data_q, sk_data_d;
  logic                  sk_last_q, sk_last_d;
  logic [CNT_WIDTH-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic                  xfer_in;
  logic                  xfer_out;

  assign xfer_in  = s_valid_i & s_ready_q;
  assign xfer_out = m_valid_q & m_ready_i;

  always_comb begin
    state_d   = state_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    sk_data_d = sk_data_q;
    sk_last_d = sk_last_q;
    unique case (state_q)
      EMPTY: begin
        if (xfer_in) begin
          m_data_d = s_data_i;
          m_last_d = s_last_i;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (xfer_in && xfer_out) begin
          m_data_d = s_data_i;
          m_last_d = s_last_i;
        end else if (xfer_in) begin
          // Downstream stalled this cycle: park the beat already in flight.
          sk_data_d = s_data_i;
          sk_last_d = s_last_i;
          state_d   = FULL;
        end else if (xfer_out) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (xfer_out) begin
          m_data_d = sk_data_q;
          m_last_d = sk_last_q;
          state_d  = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // A clear wins over a coincident last-beat handshake; that packet is not counted.
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (cnt_clr_i) begin
      pkt_cnt_d = '0;
    end else if (xfer_out && m_last_q) begin
      pkt_cnt_d = pkt_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      sk_data_q <= '0;
      sk_last_q <= 1'b0;
      pkt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      s_ready_q <= (state_d != FULL);
      m_valid_q <= (state_d != EMPTY);
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      sk_data_q <= sk_data_d;
      sk_last_q <= sk_last_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  assign s_ready_o = s_ready_q;
  assign m_valid_o = m_valid_q;
  assign m_data_o  = m_data_q;
  assign m_last_o  = m_last_q;
  assign pkt_cnt_o = pkt_cnt_q;

endmodule

// File: tb/tb_ips2l_pcie_skid_buf.sv
// Self-checking bench for ips2l_pcie_skid_buf: directed vector table, random
// scoreboard run, counter wrap/clear and asynchronous reset sequences.
module tb_ips2l_pcie_skid_buf;

  localparam int DW = 128;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sValid;
  logic          sReady;
  logic [DW-1:0] sData;
  logic          sLast;
  logic          mValid;
  logic          mReady;
  logic [DW-1:0] mData;
  logic          mLast;
  logic          cntClr;
  logic [CW-1:0] pktCnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ips2l_pcie_skid_buf #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid_i (sValid),
    .s_ready_o (sReady),
    .s_data_i  (sData),
    .s_last_i  (sLast),
    .m_valid_o (mValid),
    .m_ready_i (mReady),
    .m_data_o  (mData),
    .m_last_o  (mLast),
    .cnt_clr_i (cntClr),
    .pkt_cnt_o (pktCnt)
  );

  typedef struct {
    logic          sValid;
    logic [DW-1:0] sData;
    logic          sLast;
    logic          mReady;
    logic          cntClr;
    logic          expSReady;
    logic          expMValid;
    logic          chkData;
    logic [DW-1:0] expMData;
    logic          expMLast;
    logic [CW-1:0] expPktCnt;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mkVec(logic sv, logic [DW-1:0] sd, logic sl, logic mr, logic clr,
                                 logic esr, logic emv, logic chk, logic [DW-1:0] emd,
                                 logic eml, logic [CW-1:0] ecnt);
    vec_t v;
    v.sValid = sv; v.sData = sd; v.sLast = sl; v.mReady = mr; v.cntClr = clr;
    v.expSReady = esr; v.expMValid = emv; v.chkData = chk; v.expMData = emd;
    v.expMLast = eml; v.expPktCnt = ecnt;
    return v;
  endfunction

  task automatic applyStimulus(input logic sv, input logic [DW-1:0] sd, input logic sl,
                               input logic mr, input logic clr);
    sValid = sv;
    sData  = sd;
    sLast  = sl;
    mReady = mr;
    cntClr = clr;
  endtask

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [DW:0] sbQ[$];
  logic [DW:0] beat;
  int          sent;
  int          recv;
  int          cyc;

  initial begin
    // Streaming 1..8, last on 8
    for (int i = 0; i < 8; i++)
      vecs[i] = mkVec(1, DW'(i + 1), (i == 7), 1, 0, 1, 1, 1, DW'(i + 1), (i == 7), 16'd0);
    vecs[8]  = mkVec(0, 128'hDEAD, 0, 1, 0, 1, 0, 0, 0, 0, 16'd1);
    // Backpressure A,B,C with B parked in the skid
    vecs[9]  = mkVec(1, 128'hA, 0, 1, 0, 1, 1, 1, 128'hA, 0, 16'd1);
    vecs[10] = mkVec(1, 128'hB, 0, 0, 0, 0, 1, 1, 128'hA, 0, 16'd1);
    vecs[11] = mkVec(1, 128'hC, 1, 0, 0, 0, 1, 1, 128'hA, 0, 16'd1);
    vecs[12] = mkVec(1, 128'hC, 1, 1, 0, 1, 1, 1, 128'hB, 0, 16'd1);
    vecs[13] = mkVec(1, 128'hC, 1, 1, 0, 1, 1, 1, 128'hC, 1, 16'd1);
    vecs[14] = mkVec(0, 128'h0, 0, 1, 0, 1, 0, 0, 0, 0, 16'd2);
    // Clear coinciding with a last handshake out of FULL
    vecs[15] = mkVec(1, 128'hD, 1, 0, 0, 1, 1, 1, 128'hD, 1, 16'd2);
    vecs[16] = mkVec(1, 128'hE, 0, 0, 0, 0, 1, 1, 128'hD, 1, 16'd2);
    vecs[17] = mkVec(0, 128'h0, 0, 1, 1, 1, 1, 1, 128'hE, 0, 16'd0);
    vecs[18] = mkVec(0, 128'h0, 0, 1, 0, 1, 0, 0, 0, 0, 16'd0);
    vecs[19] = mkVec(1, 128'hF, 1, 1, 0, 1, 1, 1, 128'hF, 1, 16'd0);
    vecs[20] = mkVec(0, 128'h0, 0, 1, 0, 1, 0, 0, 0, 0, 16'd1);
    // Hold in BUSY while stalled; idle s_data must not be captured
    vecs[21] = mkVec(1, 128'h6, 0, 0, 0, 1, 1, 1, 128'h6, 0, 16'd1);
    vecs[22] = mkVec(0, 128'hBAD, 1, 0, 0, 1, 1, 1, 128'h6, 0, 16'd1);
    vecs[23] = mkVec(0, 128'h0, 0, 1, 0, 1, 0, 0, 0, 0, 16'd1);

    // Reset held with s_valid asserted
    rst_n = 1'b0;
    applyStimulus(1, 128'h55, 0, 1, 0);
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_s_ready", DW'(sReady), 0);
    checkOutput("reset_m_valid", DW'(mValid), 0);
    checkOutput("reset_pkt_cnt", DW'(pktCnt), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("release_s_ready", DW'(sReady), 1);
    checkOutput("release_m_valid", DW'(mValid), 0);

    for (int i = 0; i < 24; i++) begin
      applyStimulus(vecs[i].sValid, vecs[i].sData, vecs[i].sLast, vecs[i].mReady, vecs[i].cntClr);
      @(posedge clk); #1;
      checkOutput($sformatf("vec%0d_s_ready", i), DW'(sReady), DW'(vecs[i].expSReady));
      checkOutput($sformatf("vec%0d_m_valid", i), DW'(mValid), DW'(vecs[i].expMValid));
      checkOutput($sformatf("vec%0d_pkt_cnt", i), DW'(pktCnt), DW'(vecs[i].expPktCnt));
      if (vecs[i].chkData) begin
        checkOutput($sformatf("vec%0d_m_data", i), mData, vecs[i].expMData);
        checkOutput($sformatf("vec%0d_m_last", i), DW'(mLast), DW'(vecs[i].expMLast));
      end
    end

    // Random traffic against a FIFO scoreboard
    sent = 0; recv = 0; cyc = 0;
    while ((sent < 2000 || sbQ.size() != 0) && cyc < 20000) begin
      applyStimulus((sent < 2000) ? 1'($urandom_range(0, 1)) : 1'b0,
                    {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)),
                    (sent < 2000) ? 1'($urandom_range(0, 1)) : 1'b1, 0);
      #1;
      checkOutput("rand_s_ready", DW'(sReady), DW'(sbQ.size() < 2));
      checkOutput("rand_m_valid", DW'(mValid), DW'(sbQ.size() > 0));
      if (mValid && mReady) begin
        if (sbQ.size() == 0) begin
          checkOutput("rand_unexpected_beat", DW'(1), DW'(0));
        end else begin
          beat = sbQ.pop_front();
          checkOutput("rand_m_data", mData, beat[DW-1:0]);
          checkOutput("rand_m_last", DW'(mLast), DW'(beat[DW]));
          recv++;
        end
      end
      if (sValid && sReady) begin
        sbQ.push_back({sLast, sData});
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("rand_beats_received", DW'(recv), DW'(2000));

    // Counter wrap: 65535 single-beat packets, then one more
    applyStimulus(0, 0, 0, 1, 1);
    @(posedge clk); #1;
    checkOutput("clr_pkt_cnt", DW'(pktCnt), 0);
    applyStimulus(1, 128'h1, 1, 1, 0);
    sent = 0; cyc = 0;
    while (sent < 65535 && cyc < 70000) begin
      if (sReady) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    applyStimulus(0, 0, 0, 1, 0);
    cyc = 0;
    while (mValid && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("wrap_drain_m_valid", DW'(mValid), 0);
    checkOutput("wrap_pre_cnt", DW'(pktCnt), 16'hFFFF);
    applyStimulus(1, 128'h2, 1, 1, 0);
    @(posedge clk); #1;
    applyStimulus(0, 0, 0, 1, 0);
    @(posedge clk); #1;
    checkOutput("wrap_cnt", DW'(pktCnt), 0);

    // Asynchronous reset while FULL
    applyStimulus(1, 128'h11, 0, 0, 0);
    @(posedge clk); #1;
    applyStimulus(1, 128'h22, 0, 0, 0);
    @(posedge clk); #1;
    checkOutput("full_s_ready", DW'(sReady), 0);
    checkOutput("full_m_valid", DW'(mValid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_m_valid", DW'(mValid), 0);
    checkOutput("async_s_ready", DW'(sReady), 0);
    checkOutput("async_m_data", mData, 0);
    applyStimulus(0, 0, 0, 1, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("post_reset_s_ready", DW'(sReady), 1);
    checkOutput("post_reset_m_valid", DW'(mValid), 0);
    @(posedge clk); #1;
    checkOutput("post_reset_empty", DW'(mValid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
